// File: rtl/fb_draw_sched.sv
// fb_draw_sched: write-side scheduler for the 160x120, 9-bit colour framebuffer.
// The single draw port is shared between CPU pixel writes, which have fixed
// priority, and a rectangle-fill engine that is guaranteed one slot after
// STARVE_LIMIT consecutive CPU wins.
// Optional build macro FB_DRAW_SWAP_EN: inverted fill corners are swapped at
// capture, so the normalised rectangle is filled instead of being treated as empty.
module fb_draw_sched #(
  parameter int unsigned FB_WIDTH     = 160,
  parameter int unsigned FB_HEIGHT    = 120,
  parameter int unsigned COLOR_BITS   = 9,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  Fast_Clock,
  input  logic                  Reset,
  input  logic                  cpu_req,
  input  logic [7:0]            cpu_x,
  input  logic [6:0]            cpu_y,
  input  logic [COLOR_BITS-1:0] cpu_color,
  output logic                  cpu_ack,
  input  logic                  fill_start,
  input  logic [7:0]            fill_x0,
  input  logic [6:0]            fill_y0,
  input  logic [7:0]            fill_x1,
  input  logic [6:0]            fill_y1,
  input  logic [COLOR_BITS-1:0] fill_color,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  Enable_Draw,
  output logic [31:0]           Draw_X,
  output logic [31:0]           Draw_Y,
  output logic [31:0]           Draw_Color
);

  localparam logic [7:0] X_LIM = 8'(FB_WIDTH);
  localparam logic [7:0] X_MAX = 8'(FB_WIDTH - 1);
  localparam logic [6:0] Y_LIM = 7'(FB_HEIGHT);
  localparam logic [6:0] Y_MAX = 7'(FB_HEIGHT - 1);
  localparam int unsigned SW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t                state;
  logic [SW-1:0]         stall_cnt;
  logic [7:0]            cur_x;
  logic [6:0]            cur_y;
  logic [7:0]            rx0;
  logic [7:0]            rx1;
  logic [6:0]            ry1;
  logic [COLOR_BITS-1:0] rcolor;
  logic [7:0]            dx_q;
  logic [6:0]            dy_q;
  logic [COLOR_BITS-1:0] dc_q;

  logic [7:0] sx0, sx1, cx1;
  logic [6:0] sy0, sy1, cy1;
  logic       cap_empty;
  logic       cpu_win, fill_win, cpu_valid, last_px;

  // Normalise (optionally), clamp and classify the incoming fill command.
  always_comb begin
    sx0 = fill_x0;
    sx1 = fill_x1;
    sy0 = fill_y0;
    sy1 = fill_y1;
`ifdef FB_DRAW_SWAP_EN
    if (fill_x0 > fill_x1) begin
      sx0 = fill_x1;
      sx1 = fill_x0;
    end
    if (fill_y0 > fill_y1) begin
      sy0 = fill_y1;
      sy1 = fill_y0;
    end
`else
`endif
    cx1 = (sx1 > X_MAX) ? X_MAX : sx1;
    cy1 = (sy1 > Y_MAX) ? Y_MAX : sy1;
    cap_empty = (sx0 > cx1) || (sy0 > cy1) || (sx0 >= X_LIM) || (sy0 >= Y_LIM);
  end

  // Arbitration: CPU first unless the fill engine has been starved long enough.
  always_comb begin
    cpu_win   = cpu_req && ((state != FILL) || (stall_cnt < STARVE));
    fill_win  = (state == FILL) && !cpu_win;
    cpu_ack   = cpu_win;
    cpu_valid = (cpu_x < X_LIM) && (cpu_y < Y_LIM);
    last_px   = (cur_x == rx1) && (cur_y == ry1);
  end

  // Scheduler FSM with registered draw-port and status outputs.
  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      stall_cnt   <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      rx0         <= '0;
      rx1         <= '0;
      ry1         <= '0;
      rcolor      <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      dc_q        <= '0;
      Enable_Draw <= 1'b0;
      fill_busy   <= 1'b0;
      fill_done   <= 1'b0;
    end else begin
      Enable_Draw <= 1'b0;
      fill_done   <= 1'b0;

      if (cpu_win) begin
        if (cpu_valid) begin
          Enable_Draw <= 1'b1;
          dx_q        <= cpu_x;
          dy_q        <= cpu_y;
          dc_q        <= cpu_color;
        end
      end else if (fill_win) begin
        Enable_Draw <= 1'b1;
        dx_q        <= cur_x;
        dy_q        <= cur_y;
        dc_q        <= rcolor;
      end

      case (state)
        IDLE: begin
          if (fill_start) begin
            rx0       <= sx0;
            rx1       <= cx1;
            ry1       <= cy1;
            rcolor    <= fill_color;
            cur_x     <= sx0;
            cur_y     <= sy0;
            stall_cnt <= '0;
            if (cap_empty) begin
              state     <= DONE;
              fill_done <= 1'b1;
            end else begin
              state     <= FILL;
              fill_busy <= 1'b1;
            end
          end
        end
        FILL: begin
          if (cpu_win) begin
            stall_cnt <= stall_cnt + 1'b1;
          end else begin
            stall_cnt <= '0;
            if (last_px) begin
              state     <= DONE;
              fill_done <= 1'b1;
              fill_busy <= 1'b0;
            end else if (cur_x == rx1) begin
              cur_x <= rx0;
              cur_y <= cur_y + 1'b1;
            end else begin
              cur_x <= cur_x + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Draw_X     = 32'(dx_q);
  assign Draw_Y     = 32'(dy_q);
  assign Draw_Color = 32'(dc_q);

endmodule

// File: tb/tb_fb_draw_sched.sv
// Directed testbench for fb_draw_sched. Inputs are driven just after the
// falling edge and outputs are sampled on the falling edge.
module tb_fb_draw_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [7:0]  cpu_x;
  logic [6:0]  cpu_y;
  logic [8:0]  cpu_color;
  logic        cpu_ack;
  logic        fill_start;
  logic [7:0]  fill_x0;
  logic [6:0]  fill_y0;
  logic [7:0]  fill_x1;
  logic [6:0]  fill_y1;
  logic [8:0]  fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        en;
  logic [31:0] dx;
  logic [31:0] dy;
  logic [31:0] dc;

  int errors = 0;
  int checks = 0;

  fb_draw_sched #(
    .FB_WIDTH    (160),
    .FB_HEIGHT   (120),
    .COLOR_BITS  (9),
    .STARVE_LIMIT(4)
  ) dut (
    .Fast_Clock (clk),
    .Reset      (rst),
    .cpu_req    (cpu_req),
    .cpu_x      (cpu_x),
    .cpu_y      (cpu_y),
    .cpu_color  (cpu_color),
    .cpu_ack    (cpu_ack),
    .fill_start (fill_start),
    .fill_x0    (fill_x0),
    .fill_y0    (fill_y0),
    .fill_x1    (fill_x1),
    .fill_y1    (fill_y1),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .Enable_Draw(en),
    .Draw_X     (dx),
    .Draw_Y     (dy),
    .Draw_Color (dc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_px(input string tag, input logic e, input logic [7:0] x,
                        input logic [6:0] y, input logic [8:0] c);
    logic [96:0] o;
    logic [96:0] w;
    o = {en, dx, dy, dc};
    w = {e, 24'h0, x, 25'h0, y, 23'h0, c};
    checks++;
    assert (o === w) else begin
      errors++;
      $error("FAIL %s observed en=%0b x=%0d y=%0d c=%0h expected en=%0b x=%0d y=%0d c=%0h",
             tag, en, dx, dy, dc, e, x, y, c);
    end
  endtask

  task automatic set_fill(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] x1,
                          input logic [6:0] y1, input logic [8:0] c);
    fill_x0    = x0;
    fill_y0    = y0;
    fill_x1    = x1;
    fill_y1    = y1;
    fill_color = c;
  endtask

  initial begin
    rst        = 1'b1;
    cpu_req    = 1'b0;
    cpu_x      = '0;
    cpu_y      = '0;
    cpu_color  = '0;
    fill_start = 1'b0;
    set_fill(0, 0, 0, 0, 0);
    repeat (2) tick();
    #1;
    chk_px("reset_px", 0, 0, 0, 0);
    chk("reset_busy", 32'(fill_busy), 0);
    chk("reset_done", 32'(fill_done), 0);
    chk("reset_ack", 32'(cpu_ack), 0);
    rst = 1'b0;
    tick();

    // CPU single write, then hold of Draw_* with no grant
    cpu_req = 1'b1; cpu_x = 5; cpu_y = 6; cpu_color = 9'h123;
    #1 chk("cpu_ack_idle", 32'(cpu_ack), 1);
    tick();
    chk_px("cpu_px", 1, 5, 6, 9'h123);
    cpu_req = 1'b0;
    tick();
    chk_px("cpu_hold", 0, 5, 6, 9'h123);

    // CPU writes outside the framebuffer are acknowledged but dropped
    cpu_req = 1'b1; cpu_x = 160; cpu_y = 0;
    #1 chk("cpu_drop_ack", 32'(cpu_ack), 1);
    tick();
    chk_px("cpu_drop_x", 0, 5, 6, 9'h123);
    cpu_x = 0; cpu_y = 120;
    tick();
    chk_px("cpu_drop_y", 0, 5, 6, 9'h123);
    cpu_req = 1'b0;

    // Small fill (2,3)-(4,4), with an ignored fill_start mid-way
    set_fill(2, 3, 4, 4, 9'h0A5);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("small_busy0", 32'(fill_busy), 1);
    chk_px("small_first_idle", 0, 5, 6, 9'h123);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        set_fill(0, 0, 0, 0, 9'h1FF);
        fill_start = 1'b1;
      end
      tick();
      fill_start = 1'b0;
      chk_px("small_px", 1, 8'(2 + i % 3), 7'(3 + i / 3), 9'h0A5);
      chk("small_done", 32'(fill_done), 32'(i == 5));
      chk("small_busy", 32'(fill_busy), 32'(i != 5));
    end
    tick();
    chk("small_done_after", 32'(fill_done), 0);
    chk_px("small_idle_after", 0, 4, 4, 9'h0A5);
    tick();
    chk("small_single_done", 32'(fill_done), 0);

    // Starvation: CPU held high, simultaneous with fill_start
    set_fill(10, 10, 19, 10, 9'h033);
    fill_start = 1'b1;
    cpu_req = 1'b1; cpu_x = 1; cpu_y = 1; cpu_color = 9'h100;
    #1 chk("starve_ack_idle", 32'(cpu_ack), 1);
    tick();
    fill_start = 1'b0;
    chk_px("starve_cpu0", 1, 1, 1, 9'h100);
    chk("starve_busy", 32'(fill_busy), 1);
    for (int k = 0; k < 50; k++) begin
      #1 chk("starve_ack", 32'(cpu_ack), 32'(k % 5 != 4));
      tick();
      if (k % 5 == 4)
        chk_px("starve_fill_px", 1, 8'(10 + k / 5), 10, 9'h033);
      else
        chk_px("starve_cpu_px", 1, 1, 1, 9'h100);
      chk("starve_done", 32'(fill_done), 32'(k == 49));
    end
    cpu_req = 1'b0;
    tick();
    chk("starve_done_after", 32'(fill_done), 0);
    chk("starve_busy_after", 32'(fill_busy), 0);
    tick();

    // Clipping (150,115)-(200,127)
    set_fill(150, 115, 200, 127, 9'h1C7);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("clip_busy", 32'(fill_busy), 1);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_px("clip_px", 1, 8'(150 + i % 10), 7'(115 + i / 10), 9'h1C7);
      chk("clip_done", 32'(fill_done), 32'(i == 49));
    end
    tick();
    chk("clip_en_after", 32'(en), 0);
    tick();

    // Inverted corners (20,5)-(10,5)
    set_fill(20, 5, 10, 5, 9'h0F0);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
`ifdef FB_DRAW_SWAP_EN
    chk("swap_busy", 32'(fill_busy), 1);
    for (int i = 0; i < 11; i++) begin
      tick();
      chk_px("swap_px", 1, 8'(10 + i), 5, 9'h0F0);
      chk("swap_done", 32'(fill_done), 32'(i == 10));
    end
    tick();
    chk("swap_en_after", 32'(en), 0);
`else
    chk("empty_done", 32'(fill_done), 1);
    chk("empty_busy", 32'(fill_busy), 0);
    chk_px("empty_px", 0, 159, 119, 9'h1C7);
    tick();
    chk("empty_done_after", 32'(fill_done), 0);
    chk_px("empty_px_after", 0, 159, 119, 9'h1C7);
`endif
    tick();

    // Start X beyond the framebuffer: empty in either build
    set_fill(200, 0, 210, 0, 9'h00F);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("oob_done", 32'(fill_done), 1);
    chk("oob_en", 32'(en), 0);
    tick();
    chk("oob_en_after", 32'(en), 0);
    tick();

    // Single pixel at the far corner
    set_fill(159, 119, 159, 119, 9'h001);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("corner_busy", 32'(fill_busy), 1);
    tick();
    chk_px("corner_px", 1, 159, 119, 9'h001);
    chk("corner_done", 32'(fill_done), 1);
    chk("corner_busy_fall", 32'(fill_busy), 0);
    tick();
    tick();

    // Reset in the middle of a full-screen fill
    set_fill(0, 0, 159, 119, 9'h1FF);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_px("full_px", 1, 8'(i), 0, 9'h1FF);
    end
    #2 rst = 1'b1;
    #1;
    chk_px("midreset_px", 0, 0, 0, 0);
    chk("midreset_busy", 32'(fill_busy), 0);
    chk("midreset_done", 32'(fill_done), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postreset_done", 32'(fill_done), 0);
      chk("postreset_en", 32'(en), 0);
      chk("postreset_busy", 32'(fill_busy), 0);
    end

    // A new fill is accepted, showing the scheduler is back in IDLE
    set_fill(7, 8, 7, 8, 9'h055);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("postreset_fill_busy", 32'(fill_busy), 1);
    tick();
    chk_px("postreset_fill_px", 1, 7, 8, 9'h055);
    chk("postreset_fill_done", 32'(fill_done), 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_draw_sched.md
Name: fb_draw_sched

Overview:
- Write-side scheduler for the 160x120, 9-bit-colour framebuffer.
- Shares the single draw port (Enable_Draw/Draw_X/Draw_Y/Draw_Color) between two requesters:
  - a CPU single-pixel write requester;
  - an internal rectangle-fill engine, which iterates over a clipped rectangle and emits one pixel per granted cycle.
- The CPU has fixed priority, with an anti-starvation guarantee for the fill engine.
- All draw-port outputs are registered and sit directly in front of the framebuffer write port on Fast_Clock.

Parameters:
- FB_WIDTH, 160, framebuffer width in pixels.
- FB_HEIGHT, 120, framebuffer height in pixels.
- COLOR_BITS, 9, colour width (RGB 3:3:3).
- STARVE_LIMIT, 4, consecutive CPU-won cycles during a fill after which the fill engine is forced one slot.

Ports:
- Fast_Clock  in  1  sole clock.
- Reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU pixel-write valid (level).
- cpu_x  in  8  CPU pixel X.
- cpu_y  in  7  CPU pixel Y.
- cpu_color  in  9  CPU pixel colour.
- cpu_ack  out  1  combinational grant; a transfer occurs on an edge with cpu_req&cpu_ack.
- fill_start  in  1  single-cycle fill command.
- fill_x0  in  8  fill corner X0.
- fill_y0  in  7  fill corner Y0.
- fill_x1  in  8  fill corner X1.
- fill_y1  in  7  fill corner Y1.
- fill_color  in  9  fill colour.
- fill_busy  out  1  high while a fill is in progress.
- fill_done  out  1  one-cycle pulse at fill completion.
- Enable_Draw  out  1  framebuffer write enable.
- Draw_X  out  32  write X, zero-extended.
- Draw_Y  out  32  write Y, zero-extended.
- Draw_Color  out  32  write colour, zero-extended.

Behaviour:
- Reset (async, any state):
  - State returns to IDLE.
  - Enable_Draw, Draw_X, Draw_Y, Draw_Color, fill_busy, fill_done = 0.
  - stall_cnt = 0.
  - Any in-progress fill is abandoned with no fill_done.
- States:
  - IDLE: no fill active. cpu_ack = cpu_req.
  - FILL: walking the rectangle.
  - DONE: one cycle; asserts fill_done, then goes to IDLE.
- Command capture in IDLE, on fill_start:
  - Latch the corners and colour.
  - Clamp x1 to min(x1, FB_WIDTH-1) and y1 to min(y1, FB_HEIGHT-1).
  - If x0>x1 or y0>y1 (after clamping), or x0>=FB_WIDTH or y0>=FB_HEIGHT, the rectangle is empty: go to DONE with zero writes.
  - Otherwise set cur_x=x0, cur_y=y0, go to FILL, and set fill_busy=1 from the next cycle.
- fill_start while fill_busy=1: ignored.
- fill_start and cpu_req in the same IDLE cycle: the CPU is granted, and the fill is captured in parallel.
- Arbitration in FILL:
  - The CPU wins if cpu_req=1 and stall_cnt<STARVE_LIMIT; cpu_ack=1 and stall_cnt increments.
  - Otherwise the fill wins: cpu_ack=0, the current pixel is emitted, and stall_cnt clears.
  - With cpu_req=0 the fill wins every cycle (one pixel/cycle).
- Raster order: x increments first. At cur_x==x1, cur_x reloads to x0 and cur_y increments.
- Last pixel: after the pixel (x1,y1) is issued, go to DONE.
- Output latency:
  - The granted source's pixel appears on Draw_* with Enable_Draw=1 exactly one cycle after the grant edge.
  - With no grant, the next cycle has Enable_Draw=0 and Draw_* holds its previous values.
- Completion timing:
  - fill_done is high in the same cycle that Enable_Draw carries pixel (x1,y1).
  - fill_busy falls in that same cycle.
  - For an empty rectangle: fill_done fires one cycle after fill_start and Enable_Draw never asserts.
- CPU coordinate validity: CPU writes with cpu_x>=FB_WIDTH or cpu_y>=FB_HEIGHT are acknowledged but dropped (Enable_Draw stays 0).
- Width rules: counters are 8 bits (X) and 7 bits (Y), so there is no wrap because of clamping. Draw_* upper bits are always 0.
- Fill write count = (x1-x0+1)*(y1-y0+1), at most 19200.

Optional Feature:
- Macro: FB_DRAW_SWAP_EN.
- Defined: inverted corners (x0>x1 and/or y0>y1) are swapped at capture before clamping, so the normalised rectangle is filled.
- Undefined: inverted corners yield an empty rectangle as described above.

Test Plan:
- Reset mid-fill: fill (0,0)-(159,119) colour 0x1FF, Reset asserted at pixel 50 -> all outputs 0 immediately, no fill_done, IDLE after release.
- Fill (2,3)-(4,4) colour 0x0A5, cpu_req=0:
  - Exactly 6 writes in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4).
  - fill_done coincides with (4,4); fill_busy is high for 6 cycles.
- Starvation: fill (10,10)-(19,10) with cpu_req held high, STARVE_LIMIT=4 -> the pattern is 4 CPU writes, 1 fill write, repeated; the fill completes after 50 grant cycles.
- Clipping: fill (150,115)-(200,127) -> writes cover x 150..159 and y 115..119 (50 writes); no Draw_X>159 or Draw_Y>119.
- Empty/invalid rectangle, CPU drop:
  - Fill (20,5)-(10,5) without the macro -> fill_done one cycle later, zero writes.
  - With FB_DRAW_SWAP_EN the same fill -> 11 writes, x 10..20.
  - CPU write to (160,0) -> cpu_ack=1, Enable_Draw stays 0.
- Ignored command: fill_start issued while busy -> ignored; the original rectangle completes unchanged, with exactly one fill_done.
